// File: rtl/priority_resolver_n_if.sv
// priority_resolver_n_if: request/acknowledge bus between the
// IRR/IMR logic, the priority resolver and the data-bus block.
interface priority_resolver_n_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) ();
  logic [N-1:0] irr;
  logic [N-1:0] imr;
  logic         inta;
  logic         eoi;
  logic         seoi;
  logic [W-1:0] seoi_lvl;
  logic         set_prio;
  logic [W-1:0] prio_lvl;
  logic         rot_mode;
  logic         aeoi_mode;
  logic         smm;
  logic [N-1:0] isr;
  logic         int_req;
  logic [W-1:0] vector_id;
  logic         vector_valid;
  logic         spurious;

  modport master (
    output irr, imr, inta, eoi, seoi, seoi_lvl,
    output set_prio, prio_lvl, rot_mode, aeoi_mode, smm,
    input  isr, int_req, vector_id, vector_valid, spurious
  );

  modport slave (
    input  irr, imr, inta, eoi, seoi, seoi_lvl,
    input  set_prio, prio_lvl, rot_mode, aeoi_mode, smm,
    output isr, int_req, vector_id, vector_valid, spurious
  );
endinterface

// File: rtl/priority_resolver_n.sv
// priority_resolver_n: N-channel 8259A-style priority resolver
// with nested/rotating priority, EOI/AEOI and two-strobe INTA.
module priority_resolver_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input logic clk,
  input logic reset,
  priority_resolver_n_if.slave bus
);
  typedef enum logic {IDLE, ACK} state_t;

  state_t       state_q;
  logic [N-1:0] isr_q, isr_d;
  logic [W-1:0] lp_q, lp_d;
  logic         int_req_q;
  logic [W-1:0] vid_q;
  logic         vv_q;
  logic         spur_q;
  logic         flag_q;

  logic [N-1:0] cand, blk;
  logic         win_f, blk_f, top_f;
  logic [W-1:0] win, blk_top, top;
  logic         pending;
  logic         ack_set, aeoi_clr;
  logic [N-1:0] set_m, clr_m;

  // Highest-priority set member relative to lp; MSB = found.
  function automatic logic [W:0] pick(
    input logic [N-1:0] v,
    input logic [W-1:0] lp
  );
    logic [W-1:0] ch;
    logic [W:0]   res;
    res = '0;
    for (int r = N - 1; r >= 0; r--) begin
      ch = lp + W'(1) + W'(r);
      if (v[ch]) res = {1'b1, ch};
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rank(
    input logic [W-1:0] i,
    input logic [W-1:0] lp
  );
    return i - lp - W'(1);
  endfunction

  // Resolve winner, blocking level and pending request.
  always_comb begin
    cand = bus.irr & ~bus.imr;
    blk  = bus.smm ? (isr_q & ~bus.imr) : isr_q;
    {win_f, win}     = pick(cand, lp_q);
    {blk_f, blk_top} = pick(blk, lp_q);
    {top_f, top}     = pick(isr_q, lp_q);
    pending = win_f &&
      (!blk_f || rank(win, lp_q) < rank(blk_top, lp_q));
  end

  // Next isr and lp; an inta set beats a same-bit clear.
  always_comb begin
    ack_set  = (state_q == IDLE) && bus.inta && win_f;
    aeoi_clr = (state_q == ACK) && bus.inta &&
               bus.aeoi_mode && !flag_q;
    set_m = '0;
    clr_m = '0;
    if (ack_set) set_m[win] = 1'b1;
    if (bus.seoi) clr_m[bus.seoi_lvl] = 1'b1;
    else if (bus.eoi && top_f) clr_m[top] = 1'b1;
    if (aeoi_clr) clr_m[vid_q] = 1'b1;
    isr_d = (isr_q & ~clr_m) | set_m;
    lp_d = lp_q;
    if (bus.set_prio) begin
      lp_d = bus.prio_lvl;
    end else if (bus.rot_mode) begin
      if (bus.seoi) lp_d = bus.seoi_lvl;
      else if (bus.eoi && top_f) lp_d = top;
      else if (aeoi_clr) lp_d = vid_q;
    end
  end

  // In-service register and lowest-priority pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      isr_q <= '0;
      lp_q  <= W'(N - 1);
    end else begin
      isr_q <= isr_d;
      lp_q  <= lp_d;
    end
  end

  // Two-strobe acknowledge FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      vid_q     <= '0;
      vv_q      <= 1'b0;
      spur_q    <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      vv_q   <= 1'b0;
      spur_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          int_req_q <= pending;
          if (bus.inta) begin
            vid_q   <= win_f ? win : lp_q;
            flag_q  <= !win_f;
            state_q <= ACK;
          end
        end
        ACK: begin
          int_req_q <= 1'b0;
          if (bus.inta) begin
            vv_q    <= 1'b1;
            spur_q  <= flag_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.isr          = isr_q;
  assign bus.int_req      = int_req_q;
  assign bus.vector_id    = vid_q;
  assign bus.vector_valid = vv_q;
  assign bus.spurious     = spur_q;
endmodule

// File: tb/tb_priority_resolver_n.sv
// tb_priority_resolver_n: directed vectors and sequences for
// N=8, plus rotation wrap-around on N=4 and N=16 instances.
module tb_priority_resolver_n;
  logic clk = 1'b0;
  logic rst_n;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  priority_resolver_n_if #(.N(8))  p8 ();
  priority_resolver_n_if #(.N(4))  p4 ();
  priority_resolver_n_if #(.N(16)) p16 ();

  priority_resolver_n #(.N(8)) d8 (
    .clk(clk), .reset(rst_n), .bus(p8)
  );
  priority_resolver_n #(.N(4)) d4 (
    .clk(clk), .reset(rst_n), .bus(p4)
  );
  priority_resolver_n #(.N(16)) d16 (
    .clk(clk), .reset(rst_n), .bus(p16)
  );

  typedef struct {
    logic [2:0] lp;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       req;
    logic [2:0] vid;
    logic       spur;
  } vec_t;

  vec_t tv[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    p8.irr = '0; p8.imr = '0; p8.inta = 0; p8.eoi = 0;
    p8.seoi = 0; p8.seoi_lvl = '0; p8.set_prio = 0;
    p8.prio_lvl = '0; p8.rot_mode = 0; p8.aeoi_mode = 0;
    p8.smm = 0;
    p4.irr = '0; p4.imr = '0; p4.inta = 0; p4.eoi = 0;
    p4.seoi = 0; p4.seoi_lvl = '0; p4.set_prio = 0;
    p4.prio_lvl = '0; p4.rot_mode = 0; p4.aeoi_mode = 0;
    p4.smm = 0;
    p16.irr = '0; p16.imr = '0; p16.inta = 0; p16.eoi = 0;
    p16.seoi = 0; p16.seoi_lvl = '0; p16.set_prio = 0;
    p16.prio_lvl = '0; p16.rot_mode = 0; p16.aeoi_mode = 0;
    p16.smm = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic inta8();
    p8.inta = 1'b1;
    tick();
    p8.inta = 1'b0;
  endtask

  task automatic eoi8();
    p8.eoi = 1'b1;
    tick();
    p8.eoi = 1'b0;
  endtask

  task automatic ack8();
    inta8();
    inta8();
  endtask

  task automatic ack_wide();
    for (int k = 0; k < 2; k++) begin
      p4.inta = 1'b1; p16.inta = 1'b1;
      tick();
      p4.inta = 1'b0; p16.inta = 1'b0;
    end
  endtask

  task automatic eoi_wide();
    p4.eoi = 1'b1; p16.eoi = 1'b1;
    tick();
    p4.eoi = 1'b0; p16.eoi = 1'b0;
  endtask

  initial begin
    logic [7:0] eisr;
    tv[0] = '{3'd7, 8'h28, 8'h00, 1'b1, 3'd3, 1'b0};
    tv[1] = '{3'd7, 8'h28, 8'h08, 1'b1, 3'd5, 1'b0};
    tv[2] = '{3'd2, 8'h0A, 8'h00, 1'b1, 3'd3, 1'b0};
    tv[3] = '{3'd4, 8'h21, 8'h00, 1'b1, 3'd5, 1'b0};
    tv[4] = '{3'd0, 8'h81, 8'h00, 1'b1, 3'd7, 1'b0};
    tv[5] = '{3'd7, 8'hFF, 8'hFF, 1'b0, 3'd7, 1'b1};
    tv[6] = '{3'd3, 8'h00, 8'h00, 1'b0, 3'd3, 1'b1};
    tv[7] = '{3'd6, 8'hC0, 8'h00, 1'b1, 3'd7, 1'b0};
    tv[8] = '{3'd7, 8'h80, 8'h00, 1'b1, 3'd7, 1'b0};
    tv[9] = '{3'd5, 8'h41, 8'h40, 1'b1, 3'd0, 1'b0};

    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_isr", p8.isr, 0);
    chk("rst_int_req", p8.int_req, 0);
    chk("rst_vid", p8.vector_id, 0);
    chk("rst_vv", p8.vector_valid, 0);
    chk("rst_spur", p8.spurious, 0);

    rst_n = 1'b1;
    p8.irr = 8'h28;
    tick();
    chk("basic_req", p8.int_req, 1);
    inta8();
    chk("basic_isr", p8.isr, 8'h08);
    chk("basic_vv_early", p8.vector_valid, 0);
    inta8();
    chk("basic_vv", p8.vector_valid, 1);
    chk("basic_vid", p8.vector_id, 3);
    chk("basic_spur", p8.spurious, 0);
    tick();
    chk("basic_vv_drop", p8.vector_valid, 0);

    for (int i = 0; i < 10; i++) begin
      idle_all();
      do_reset();
      p8.set_prio = 1'b1;
      p8.prio_lvl = tv[i].lp;
      tick();
      p8.set_prio = 1'b0;
      p8.irr = tv[i].irr;
      p8.imr = tv[i].imr;
      tick();
      chk($sformatf("tv%0d_req", i), p8.int_req, tv[i].req);
      ack8();
      eisr = tv[i].spur ? 8'h00 : (8'h01 << tv[i].vid);
      chk($sformatf("tv%0d_vv", i), p8.vector_valid, 1);
      chk($sformatf("tv%0d_vid", i), p8.vector_id, tv[i].vid);
      chk($sformatf("tv%0d_spur", i), p8.spurious, tv[i].spur);
      chk($sformatf("tv%0d_isr", i), p8.isr, eisr);
    end

    idle_all();
    do_reset();
    p8.irr = 8'h08;
    tick();
    ack8();
    p8.irr = 8'h20;
    tick();
    tick();
    chk("nest_blocked", p8.int_req, 0);
    p8.irr = 8'h22;
    tick();
    chk("nest_req", p8.int_req, 1);
    ack8();
    chk("nest_vid", p8.vector_id, 1);
    chk("nest_isr", p8.isr, 8'h0A);
    p8.irr = 8'h00;
    eoi8();
    chk("nest_eoi", p8.isr, 8'h08);

    idle_all();
    p8.rot_mode = 1'b1;
    do_reset();
    p8.irr = 8'h04;
    tick();
    ack8();
    chk("rot_vid2", p8.vector_id, 2);
    p8.irr = 8'h00;
    eoi8();
    chk("rot_isr0", p8.isr, 0);
    p8.irr = 8'h0A;
    tick();
    ack8();
    chk("rot_vid3", p8.vector_id, 3);

    idle_all();
    do_reset();
    p8.irr = 8'h01;
    tick();
    ack8();
    p8.irr = 8'h80;
    ack8();
    chk("seoi_pre", p8.isr, 8'h81);
    p8.irr = 8'h00;
    p8.seoi = 1'b1;
    p8.seoi_lvl = 3'd7;
    tick();
    p8.seoi = 1'b0;
    chk("seoi_clr", p8.isr, 8'h01);
    p8.imr = 8'h01;
    p8.irr = 8'h04;
    tick();
    tick();
    chk("smm_off", p8.int_req, 0);
    p8.smm = 1'b1;
    tick();
    chk("smm_on", p8.int_req, 1);

    idle_all();
    p8.aeoi_mode = 1'b1;
    p8.rot_mode = 1'b1;
    do_reset();
    p8.irr = 8'h40;
    tick();
    inta8();
    chk("aeoi_mid", p8.isr, 8'h40);
    inta8();
    chk("aeoi_isr", p8.isr, 0);
    chk("aeoi_vid", p8.vector_id, 6);
    p8.irr = 8'h81;
    tick();
    ack8();
    chk("aeoi_rot_vid", p8.vector_id, 7);

    idle_all();
    do_reset();
    p8.irr = 8'h10;
    tick();
    inta8();
    p8.irr = 8'h00;
    inta8();
    chk("drop_vid", p8.vector_id, 4);
    chk("drop_spur", p8.spurious, 0);

    idle_all();
    do_reset();
    p8.irr = 8'h04;
    tick();
    p8.inta = 1'b1;
    p8.seoi = 1'b1;
    p8.seoi_lvl = 3'd2;
    tick();
    p8.inta = 1'b0;
    p8.seoi = 1'b0;
    chk("set_wins", p8.isr, 8'h04);
    inta8();
    p8.irr = 8'h01;
    ack8();
    chk("two_isr", p8.isr, 8'h05);
    p8.eoi = 1'b1;
    p8.seoi = 1'b1;
    tick();
    p8.eoi = 1'b0;
    p8.seoi = 1'b0;
    chk("seoi_over_eoi", p8.isr, 8'h01);

    idle_all();
    do_reset();
    p8.irr = 8'h04;
    tick();
    inta8();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midack_isr", p8.isr, 0);
    chk("midack_req", p8.int_req, 0);
    chk("midack_vv", p8.vector_valid, 0);
    inta8();
    chk("midack_idle", p8.vector_valid, 0);
    inta8();
    chk("midack_vv2", p8.vector_valid, 1);
    chk("midack_vid", p8.vector_id, 2);

    idle_all();
    p4.rot_mode = 1'b1;
    p16.rot_mode = 1'b1;
    do_reset();
    p4.irr = 4'h9;
    p16.irr = 16'h8001;
    tick();
    chk("n4_req", p4.int_req, 1);
    chk("n16_req", p16.int_req, 1);
    ack_wide();
    chk("n4_vid_a", p4.vector_id, 0);
    chk("n16_vid_a", p16.vector_id, 0);
    eoi_wide();
    ack_wide();
    chk("n4_vid_b", p4.vector_id, 3);
    chk("n16_vid_b", p16.vector_id, 15);
    eoi_wide();
    chk("n4_isr", p4.isr, 0);
    chk("n16_isr", p16.isr, 0);
    ack_wide();
    chk("n4_wrap", p4.vector_id, 0);
    chk("n16_wrap", p16.vector_id, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end
endmodule

// File: doc/priority_resolver_n.md
# priority_resolver_n

Parametrised successor to the 8-input priority resolver in the 8259A-style interrupt controller. Resolves N interrupt requests against the mask and in-service registers. Supports fully nested and rotating priority, specific and non-specific EOI, and automatic EOI. Runs the two-strobe INTA acknowledge sequence and sits between the IRR/IMR logic and the control/data-bus block that drives the vector onto the bus.

## Interface
- N, default 8: number of request channels; power of 2, range 2..32.
- W, default $clog2(N): width of level and index fields.
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- irr  in  N  pending requests (level, already edge/level-conditioned upstream).
- imr  in  N  mask; 1 = channel masked.
- inta  in  1  acknowledge strobe; one cycle per INTA pulse.
- eoi  in  1  non-specific EOI strobe.
- seoi  in  1  specific EOI strobe; clears level seoi_lvl.
- seoi_lvl  in  W  target level for seoi.
- set_prio  in  1  strobe: load lowest-priority pointer with prio_lvl.
- prio_lvl  in  W  new lowest-priority level.
- rot_mode  in  1  1 = rotate priority on EOI.
- aeoi_mode  in  1  1 = clear ISR bit automatically at the second inta.
- smm  in  1  special mask mode; masked ISR bits do not block lower levels.
- isr  out  N  in-service register.
- int_req  out  1  registered interrupt request to the CPU.
- vector_id  out  W  acknowledged level; valid with vector_valid.
- vector_valid  out  1  one-cycle pulse after the second inta.
- spurious  out  1  qualifies vector_valid; 1 = no request was present at the first inta.

## Operation
- Priority pointer lp (W bits) holds the lowest-priority level. The highest-priority level is (lp+1) mod N.
- Rank of channel i = (i − lp − 1) mod N, computed in W-bit wrap arithmetic. Rank 0 is the highest priority.
- Candidate set: irr & ~imr.
- winner: the candidate with the smallest rank.
- Blocking set: isr, or isr & ~imr when smm=1.
- top_isr: the member of the blocking set with the smallest rank.
- Pending is true when a winner exists and either the blocking set is empty or rank(winner) < rank(top_isr).
- The FSM has two states, IDLE and ACK.
- IDLE:
  - int_req register ← pending.
  - On inta: latch vector_id ← winner, set isr[winner], go to ACK.
  - If no winner exists at that inta: latch vector_id ← (lp) (lowest-priority level), set the spurious flag, leave isr unchanged, go to ACK.
- ACK:
  - int_req ← 0.
  - On inta: assert vector_valid and spurious (flag) for one cycle, then return to IDLE.
  - If aeoi_mode=1 and the acknowledge was not spurious, clear isr[vector_id] at this inta.
  - If aeoi_mode=1 and rot_mode=1, also set lp ← vector_id.
- Non-specific eoi clears isr[top_isr], using full isr regardless of smm. If rot_mode=1, lp ← top_isr. If isr=0, eoi is a no-op.
- seoi clears isr[seoi_lvl]. If rot_mode=1, lp ← seoi_lvl.
- set_prio sets lp ← prio_lvl.
- Precedence within one cycle:
  - seoi overrides eoi.
  - For lp, set_prio has priority over any EOI rotation.
  - An EOI clear and an inta set of different bits both take effect.
  - If both target the same bit, the set wins.
- All decisions use register values from the start of the cycle.

## Timing
- Reset values: isr=0, lp=N−1 (channel 0 highest), FSM=IDLE, int_req=0, vector_id=0, vector_valid=0, spurious=0.
- Reset mid-sequence (ACK) aborts the acknowledge: no vector_valid pulse, and isr is cleared.
- int_req latency: one clock from an irr/imr/isr/lp change to the int_req update.
- isr and lp update at the same edge that samples the inta, eoi, seoi or set_prio strobe.
- vector_valid is high for exactly the cycle after the edge that sampled the second inta.
- Strobes are single-cycle. A strobe held for k cycles acts as k strobes.
- In ACK, only inta advances the FSM. EOI and set_prio are still honoured in ACK.
- A request that drops between the two inta strobes still returns the level latched at the first inta.
- Wrap-around: rank arithmetic is mod N; lp=N−1 rotates to 0 with no special case.

## Test plan
- Reset and basic acknowledge: reset=0 for 2 cycles, then irr=8'h28, imr=0 → int_req=1 one cycle later. First inta → isr=8'h08. Second inta → vector_id=3, vector_valid pulse, spurious=0.
- Fully nested: isr=8'h08, irr=8'h20 → int_req stays 0. Raise irr bit 1 → int_req=1. Acknowledge → isr=8'h0A. eoi → isr=8'h08.
- Rotation: rot_mode=1, acknowledge level 2, then eoi → lp=2, isr=0. irr=8'h0A → winner is 3 (rank 0), not 1.
- Specific EOI and set_prio: isr=8'h81, seoi with seoi_lvl=7 → isr=8'h01. set_prio with prio_lvl=4 → lp=4, and the next winner among irr=8'h21 is 5.
- Spurious and AEOI: irr drops to 0 before the first inta → second inta gives vector_id=N−1 (lp), spurious=1, isr unchanged. With aeoi_mode=1, acknowledging level 6 leaves isr=0 after the second inta.
- Parameter sweep and reset mid-ACK: N=4 and N=16, lp wrapping from N−1 to 0. reset=0 while in ACK → isr=0, no vector_valid pulse, int_req=0.
